// File: rtl/ddr3_test_pkg.sv
// Shared constants for the DDR3 data-exercise SM and the read checker:
// command codes, test addresses, the fixed write pattern and checker states.
package ddr3_test_pkg;

  // DDR3 core command codes
  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  // Test addresses used by the exercise SM
  localparam logic [27:0] ADDRESS1 = 28'h000_0100;
  localparam logic [27:0] ADDRESS2 = 28'h000_0200;

  // Fixed write pattern, listed in read-return order
  localparam logic [63:0] DATA1_1 = 64'h1AAA2AAA3AAA4AAA;
  localparam logic [63:0] DATA1_2 = 64'hE555D555C555B555;
  localparam logic [63:0] DATA2_1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] DATA2_2 = 64'hFEDCBA9876543210;

  localparam int unsigned PAT_BEATS = 4;

  // Index 0 is the first beat returned
  localparam logic [PAT_BEATS-1:0][63:0] EXP_TABLE = {DATA2_2, DATA2_1, DATA1_2, DATA1_1};

  // Read checker states
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StDone    = 2'd2
  } chk_state_e;

  // Expected read data for a given beat position
  function automatic logic [63:0] exp_beat(input logic [1:0] idx);
    return EXP_TABLE[idx];
  endfunction

endpackage

// File: rtl/ddr3_timeout_timer.sv
// Run timer for the read checker: cleared on arm, counts while enabled and
// flags expiry when it reaches TIMEOUT_CYCLES-1. Holds at expiry so it never wraps.
module ddr3_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Expiry flag is a pure decode of the current count
  always_comb begin
    expire = (count_q == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  // Next count: clear has priority, then count up until expiry
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expire) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ddr3_read_checker.sv
// Checks DDR3 read returns against the fixed write pattern, counts mismatching
// beats, latches the first bad beat and flags timeouts and sticky error events.
module ddr3_read_checker
  import ddr3_test_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned NUM_BEATS      = PAT_BEATS,
  parameter int unsigned ERR_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic [63:0]      read_data,
  input  logic             read_data_valid,
  input  logic             wl_err,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       first_err_idx,
  output logic [63:0]      first_err_data,
  output logic             timeout,
  output logic             stray_beat,
  output logic             overrun,
  output logic             wl_err_seen
);

  localparam logic [1:0] LAST_BEAT = 2'(NUM_BEATS - 1);

  chk_state_e       state_q, state_d;
  logic [1:0]       beat_idx_q, beat_idx_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [1:0]       first_err_idx_q, first_err_idx_d;
  logic [63:0]      first_err_data_q, first_err_data_d;
  logic             timeout_q, timeout_d;
  logic             stray_q, stray_d;
  logic             overrun_q, overrun_d;
  logic             wl_seen_q, wl_seen_d;

  logic timer_clear;
  logic timer_enable;
  logic timer_expire;

  ddr3_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (timer_clear),
    .enable(timer_enable),
    .expire(timer_expire)
  );

  // Next-state, beat compare and status bookkeeping
  always_comb begin
    state_d          = state_q;
    beat_idx_d       = beat_idx_q;
    err_cnt_d        = err_cnt_q;
    first_err_idx_d  = first_err_idx_q;
    first_err_data_d = first_err_data_q;
    timeout_d        = timeout_q;
    stray_d          = stray_q;
    overrun_d        = overrun_q;
    wl_seen_d        = wl_seen_q | wl_err;
    timer_clear      = 1'b0;
    timer_enable     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (read_data_valid) begin
          stray_d = 1'b1;
        end
        if (arm) begin
          state_d          = StCollect;
          beat_idx_d       = '0;
          err_cnt_d        = '0;
          first_err_idx_d  = '0;
          first_err_data_d = '0;
          timeout_d        = 1'b0;
          timer_clear      = 1'b1;
        end
      end

      StCollect: begin
        timer_enable = 1'b1;
        if (read_data_valid) begin
          if (read_data != exp_beat(beat_idx_q)) begin
            // First mismatch of the run is recorded before the count moves
            if (err_cnt_q == '0) begin
              first_err_idx_d  = beat_idx_q;
              first_err_data_d = read_data;
            end
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + 1'b1;
            end
          end
          beat_idx_d = beat_idx_q + 1'b1;
        end
        // A final beat on the expiry cycle completes the run normally
        if (read_data_valid && (beat_idx_q == LAST_BEAT)) begin
          state_d = StDone;
        end else if (timer_expire) begin
          state_d   = StDone;
          timeout_d = 1'b1;
        end
      end

      StDone: begin
        if (read_data_valid) begin
          overrun_d = 1'b1;
        end
        if (arm) begin
          state_d          = StCollect;
          beat_idx_d       = '0;
          err_cnt_d        = '0;
          first_err_idx_d  = '0;
          first_err_data_d = '0;
          timeout_d        = 1'b0;
          timer_clear      = 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= StIdle;
      beat_idx_q       <= '0;
      err_cnt_q        <= '0;
      first_err_idx_q  <= '0;
      first_err_data_q <= '0;
      timeout_q        <= 1'b0;
      stray_q          <= 1'b0;
      overrun_q        <= 1'b0;
      wl_seen_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      beat_idx_q       <= beat_idx_d;
      err_cnt_q        <= err_cnt_d;
      first_err_idx_q  <= first_err_idx_d;
      first_err_data_q <= first_err_data_d;
      timeout_q        <= timeout_d;
      stray_q          <= stray_d;
      overrun_q        <= overrun_d;
      wl_seen_q        <= wl_seen_d;
    end
  end

  // Outputs decoded from registered state; pass tracks wl_err_seen live
  always_comb begin
    busy           = (state_q == StCollect);
    done           = (state_q == StDone);
    pass           = done && (err_cnt_q == '0) && !timeout_q && !wl_seen_q;
    err_cnt        = err_cnt_q;
    first_err_idx  = first_err_idx_q;
    first_err_data = first_err_data_q;
    timeout        = timeout_q;
    stray_beat     = stray_q;
    overrun        = overrun_q;
    wl_err_seen    = wl_seen_q;
  end

endmodule
